// File: rtl/pwm_unit_pkg.sv
// Shared register map and CTRL bit positions for the PWM block.
// The SFR software header uses the same offsets.
package pwm_unit_pkg;

  // Halfword register offsets within the PWM select region
  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_PRESC     = 8'h02;
  localparam logic [7:0] REG_PERIOD    = 8'h04;
  localparam logic [7:0] REG_COUNT     = 8'h06;
  localparam logic [7:0] REG_DUTY_BASE = 8'h10;
  localparam logic [7:0] REG_CH_STRIDE = 8'h04;
  localparam logic [7:0] REG_PIN_OFS   = 8'h02;

  // CTRL bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_FORCE = 1;
  localparam int CTRL_WRAPF = 15;

  // Width of a channel's pin-index register
  localparam int PIN_W = 6;

  function automatic logic [7:0] duty_addr(input int k);
    return REG_DUTY_BASE + REG_CH_STRIDE * 8'(k);
  endfunction

  function automatic logic [7:0] pin_addr(input int k);
    return duty_addr(k) + REG_PIN_OFS;
  endfunction

endpackage

// File: rtl/pwm_unit_if.sv
// SFR-style register bus for the PWM region: select, halfword address,
// read strobe, byte write enables and combinational read data.
interface pwm_unit_if;
  logic        sel;
  logic [7:0]  addr;
  logic        r;
  logic [1:0]  w;
  logic [15:0] dwrite;
  logic [15:0] pwm_data;

  modport master (output sel, addr, r, w, dwrite, input pwm_data);
  modport slave  (input sel, addr, r, w, dwrite, output pwm_data);
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: DUTY/PIN registers, DUTY shadow, compare against the
// shared counter and a one-hot routed output vector.
module pwm_channel
  import pwm_unit_pkg::*;
#(
  parameter int PINS = 36
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [1:0]       duty_we,
  input  logic             pin_we,
  input  logic [15:0]      dwrite,
  input  logic             load,
  input  logic             en,
  input  logic [15:0]      count,
  output logic [15:0]      duty,
  output logic [PIN_W-1:0] pin,
  output logic [PINS-1:0]  routed
);

  logic [15:0]      duty_reg;
  logic [15:0]      duty_act_reg;
  logic [PIN_W-1:0] pin_reg;
  logic             out_reg;

  // Software-visible registers follow the SFR falling-edge write timing.
  always_ff @(negedge clk or negedge nreset) begin
    if (!nreset) begin
      duty_reg <= '0;
      pin_reg  <= '0;
    end else begin
      if (duty_we[0]) duty_reg[7:0]  <= dwrite[7:0];
      if (duty_we[1]) duty_reg[15:8] <= dwrite[15:8];
      if (pin_we)     pin_reg        <= dwrite[PIN_W-1:0];
    end
  end

  // Shadow load and registered compare; the output trails count by one edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      duty_act_reg <= '0;
      out_reg      <= 1'b0;
    end else begin
      if (load) duty_act_reg <= duty_reg;
      out_reg <= en && (count < duty_act_reg);
    end
  end

  // Pin indices at or beyond PINS match no bit, leaving the channel unrouted.
  for (genvar gi = 0; gi < PINS; gi++) begin : g_route
    assign routed[gi] = out_reg && (int'(pin_reg) == gi);
  end

  assign duty = duty_reg;
  assign pin  = pin_reg;

endmodule

// File: rtl/pwm_unit.sv
// Multi-channel PWM generator with a shared prescaled period counter and
// double-buffered PERIOD/DUTY; channel outputs are ORed onto pwm[PINS-1:0].
module pwm_unit
  import pwm_unit_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int PINS     = 36
) (
  input  logic            clk,
  input  logic            nreset,
  pwm_unit_if.slave       bus,
  output logic [PINS-1:0] pwm,
  output logic            wrap
);

  logic [7:0]       a;
  logic             unused_addr0;
  logic             wr_ctrl, wr_presc, wr_period;
  logic             en_reg, force_tog_reg, force_ack_reg, wrapf_reg, wrap_reg;
  logic [15:0]      presc_reg, period_reg;
  logic [15:0]      presc_cnt_reg, count_reg, period_act_reg;
  logic             force_pend, tick, wrap_evt, load_shadow;
  logic [15:0]      rd_data;
  logic [PINS-1:0]  pwm_or;
  logic [15:0]      ch_duty   [CHANNELS];
  logic [PIN_W-1:0] ch_pin    [CHANNELS];
  logic [PINS-1:0]  ch_routed [CHANNELS];

  assign a            = {bus.addr[7:1], 1'b0};
  assign unused_addr0 = bus.addr[0];
  assign wr_ctrl      = bus.sel && (a == REG_CTRL);
  assign wr_presc     = bus.sel && (a == REG_PRESC);
  assign wr_period    = bus.sel && (a == REG_PERIOD);

  // FORCE is a toggle handshake between the two edges: the write side flips
  // force_tog_reg, the counter side acknowledges on the next rising edge.
  assign force_pend  = force_tog_reg ^ force_ack_reg;
  assign tick        = presc_cnt_reg >= presc_reg;
  assign wrap_evt    = en_reg && !force_pend && tick && (count_reg >= period_act_reg);
  assign load_shadow = !en_reg || force_pend || wrap_evt;

  // Global registers written on the falling edge; a pending wrap beats a WRAPF clear.
  always_ff @(negedge clk or negedge nreset) begin
    if (!nreset) begin
      en_reg        <= 1'b0;
      force_tog_reg <= 1'b0;
      wrapf_reg     <= 1'b0;
      presc_reg     <= '0;
      period_reg    <= '0;
    end else begin
      if (wr_ctrl && bus.w[0]) begin
        en_reg <= bus.dwrite[CTRL_EN];
        if (bus.dwrite[CTRL_FORCE]) force_tog_reg <= ~force_tog_reg;
      end
      if (wrap_reg) wrapf_reg <= 1'b1;
      else if (wr_ctrl && bus.w[1] && bus.dwrite[CTRL_WRAPF]) wrapf_reg <= 1'b0;
      if (wr_presc && bus.w[0])  presc_reg[7:0]   <= bus.dwrite[7:0];
      if (wr_presc && bus.w[1])  presc_reg[15:8]  <= bus.dwrite[15:8];
      if (wr_period && bus.w[0]) period_reg[7:0]  <= bus.dwrite[7:0];
      if (wr_period && bus.w[1]) period_reg[15:8] <= bus.dwrite[15:8];
    end
  end

  // Prescaler, period counter, PERIOD shadow and the wrap pulse.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      force_ack_reg  <= 1'b0;
      presc_cnt_reg  <= '0;
      count_reg      <= '0;
      period_act_reg <= '0;
      wrap_reg       <= 1'b0;
    end else begin
      force_ack_reg <= force_tog_reg;
      wrap_reg      <= wrap_evt;
      if (load_shadow) period_act_reg <= period_reg;
      if (!en_reg || force_pend) begin
        presc_cnt_reg <= '0;
        count_reg     <= '0;
      end else if (tick) begin
        presc_cnt_reg <= '0;
        count_reg     <= wrap_evt ? 16'd0 : count_reg + 16'd1;
      end else begin
        presc_cnt_reg <= presc_cnt_reg + 16'd1;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic hit_duty, hit_pin;
    assign hit_duty = bus.sel && (a == duty_addr(gi));
    assign hit_pin  = bus.sel && (a == pin_addr(gi));

    pwm_channel #(.PINS(PINS)) u_ch (
      .clk     (clk),
      .nreset  (nreset),
      .duty_we (bus.w & {2{hit_duty}}),
      .pin_we  (hit_pin && bus.w[0]),
      .dwrite  (bus.dwrite),
      .load    (load_shadow),
      .en      (en_reg),
      .count   (count_reg),
      .duty    (ch_duty[gi]),
      .pin     (ch_pin[gi]),
      .routed  (ch_routed[gi])
    );
  end

  // Channels sharing a pin are ORed together.
  always_comb begin
    pwm_or = '0;
    for (int k = 0; k < CHANNELS; k++) pwm_or = pwm_or | ch_routed[k];
  end

  // Read mux; unmapped offsets and idle cycles return 0.
  always_comb begin
    rd_data = '0;
    if (bus.r && bus.sel) begin
      case (a)
        REG_CTRL: begin
          rd_data[CTRL_WRAPF] = wrapf_reg || wrap_reg;
          rd_data[CTRL_FORCE] = force_pend;
          rd_data[CTRL_EN]    = en_reg;
        end
        REG_PRESC:  rd_data = presc_reg;
        REG_PERIOD: rd_data = period_reg;
        REG_COUNT:  rd_data = count_reg;
        default:    rd_data = '0;
      endcase
      for (int k = 0; k < CHANNELS; k++) begin
        if (a == duty_addr(k)) rd_data = ch_duty[k];
        if (a == pin_addr(k))  rd_data = {{(16-PIN_W){1'b0}}, ch_pin[k]};
      end
    end
  end

  assign bus.pwm_data = rd_data;
  assign pwm          = pwm_or;
  assign wrap         = wrap_reg;

endmodule

// File: tb/tb_pwm_unit.sv
// Self-checking bench for pwm_unit: register access, a table of channel
// configurations, hand-written corner sequences and randomized configs
// checked cycle by cycle against an arithmetic model of the period timing.
module tb_pwm_unit;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [35:0] pwm;
  logic        wrap;

  pwm_unit_if bus_if ();

  pwm_unit #(.CHANNELS(4), .PINS(36)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus_if),
    .pwm    (pwm),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int presc;
    int period;
    int duty [4];
    int pin  [4];
    int probe;
    int exp_high;
    int exp_gap;
  } row_t;

  row_t        rows [8];
  int          cfg_duty [4];
  int          cfg_pin  [4];
  logic [15:0] rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] we);
    @(posedge clk);
    #1;
    bus_if.sel = 1'b1; bus_if.addr = a; bus_if.dwrite = d; bus_if.w = we;
    @(negedge clk);
    #1;
    bus_if.sel = 1'b0; bus_if.w = 2'b00;
  endtask

  task automatic rdr(input logic [7:0] a, output logic [15:0] d);
    bus_if.sel = 1'b1; bus_if.r = 1'b1; bus_if.addr = a;
    #1;
    d = bus_if.pwm_data;
    bus_if.sel = 1'b0; bus_if.r = 1'b0;
  endtask

  task automatic set_row(input int i, input int presc, input int period,
                         input int d0, input int d1, input int d2, input int d3,
                         input int p0, input int p1, input int p2, input int p3,
                         input int probe, input int high, input int gap);
    rows[i].presc = presc; rows[i].period = period;
    rows[i].duty[0] = d0; rows[i].duty[1] = d1; rows[i].duty[2] = d2; rows[i].duty[3] = d3;
    rows[i].pin[0] = p0; rows[i].pin[1] = p1; rows[i].pin[2] = p2; rows[i].pin[3] = p3;
    rows[i].probe = probe; rows[i].exp_high = high; rows[i].exp_gap = gap;
  endtask

  // Stop, program everything, then enable together with FORCE so the
  // following rising edge is a clean period start (reference edge j=0).
  task automatic program_cfg(input int presc, input int period);
    wr(8'h00, 16'h0000, 2'b01);
    wr(8'h02, 16'(presc), 2'b11);
    wr(8'h04, 16'(period), 2'b11);
    for (int k = 0; k < 4; k++) begin
      wr(8'h10 + 8'(4*k), 16'(cfg_duty[k]), 2'b11);
      wr(8'h12 + 8'(4*k), 16'(cfg_pin[k]), 2'b11);
    end
    wr(8'h00, 16'h0003, 2'b01);
  endtask

  // Counter value after rising edge j of a run started at j=0:
  // one tick per presc+1 clocks, counting modulo period+1.
  function automatic int mcnt(input int j, input int p, input int per);
    return (j / (p + 1)) % (per + 1);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs, others, nwrap, w0, w1, found, per, p;
    logic [35:0] mask, exp_pwm;
    logic        exp_wrap;

    bus_if.sel = 1'b0; bus_if.r = 1'b0; bus_if.w = 2'b00;
    bus_if.addr = 8'h00; bus_if.dwrite = 16'h0000;

    // ---- reset state ----
    #12;
    chk("reset_pwm", 64'(pwm), 64'd0);
    chk("reset_wrap", 64'(wrap), 64'd0);
    #11 nreset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rdr(8'h00 + 8'(2*i), rd); chk("reset_global_reg", 64'(rd), 64'd0);
      rdr(8'h10 + 8'(4*i), rd); chk("reset_duty", 64'(rd), 64'd0);
      rdr(8'h12 + 8'(4*i), rd); chk("reset_pin", 64'(rd), 64'd0);
    end
    nwrap = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (wrap) nwrap++;
      if (pwm != 0) nwrap++;
    end
    chk("idle_no_wrap_no_pwm", 64'(nwrap), 64'd0);

    // ---- register access ----
    wr(8'h00, 16'h0002, 2'b01);
    rdr(8'h00, rd); chk("force_readback", 64'(rd), 64'h0002);
    @(posedge clk); #1;
    rdr(8'h00, rd); chk("force_selfclear", 64'(rd), 64'h0000);
    wr(8'h02, 16'h1234, 2'b11);
    wr(8'h02, 16'hFFAB, 2'b01);
    rdr(8'h02, rd); chk("presc_low_lane", 64'(rd), 64'h12AB);
    wr(8'h02, 16'h56CD, 2'b10);
    rdr(8'h02, rd); chk("presc_high_lane", 64'(rd), 64'h56AB);
    wr(8'h05, 16'h0042, 2'b11);
    rdr(8'h04, rd); chk("period_addr_bit0", 64'(rd), 64'h0042);
    rdr(8'h05, rd); chk("period_read_bit0", 64'(rd), 64'h0042);
    wr(8'h08, 16'hBEEF, 2'b11);
    rdr(8'h08, rd); chk("unmapped_read", 64'(rd), 64'h0000);
    wr(8'h06, 16'h5555, 2'b11);
    rdr(8'h06, rd); chk("count_readonly", 64'(rd), 64'h0000);
    bus_if.sel = 1'b1; bus_if.r = 1'b0; bus_if.addr = 8'h02;
    #1 chk("no_read_strobe", 64'(bus_if.pwm_data), 64'h0000);
    bus_if.sel = 1'b0;

    // ---- table of configurations: highs per window, wrap spacing ----
    set_row(0, 0, 9, 3, 0, 0, 0,  5, 63, 63, 63,  5,  3, 10);
    set_row(1, 3, 1, 0, 0, 0, 0, 63,  7, 63, 63,  7,  0,  8);
    set_row(2, 3, 1, 0, 5, 0, 0, 63,  7, 63, 63,  7,  8,  8);
    set_row(3, 0, 9, 2, 6, 0, 0,  2,  2, 63, 63,  2,  6, 10);
    set_row(4, 0, 9, 0, 0, 4, 0, 63, 63, 40, 63,  0,  0, 10);
    set_row(5, 1, 0, 1, 0, 0, 0, 35, 63, 63, 63, 35,  2,  2);
    set_row(6, 2, 4, 0, 0, 0, 5, 63, 63, 63,  0,  0, 15, 15);
    set_row(7, 1, 3, 2, 0, 0, 0, 10, 63, 63, 63, 10,  4,  8);
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) begin
        cfg_duty[k] = rows[r].duty[k];
        cfg_pin[k]  = rows[r].pin[k];
      end
      program_cfg(rows[r].presc, rows[r].period);
      repeat (3) @(posedge clk);
      mask = '0; mask[rows[r].probe] = 1'b1;
      highs = 0; others = 0; nwrap = 0; w0 = 0; w1 = 0;
      for (int c = 0; c < 3 * rows[r].exp_gap; c++) begin
        @(posedge clk); #2;
        if (pwm[rows[r].probe]) highs++;
        if ((pwm & ~mask) != 0) others++;
        if (wrap) begin
          if (nwrap == 0) w0 = c;
          if (nwrap == 1) w1 = c;
          nwrap++;
        end
      end
      $display("row %0d: highs=%0d wraps=%0d gap=%0d others=%0d", r, highs, nwrap, w1 - w0, others);
      chk("row_highs", 64'(highs), 64'(3 * rows[r].exp_high));
      chk("row_wraps", 64'(nwrap), 64'd3);
      chk("row_wrap_gap", 64'(w1 - w0), 64'(rows[r].exp_gap));
      chk("row_other_pins", 64'(others), 64'd0);
    end

    // ---- DUTY update mid-period: old pulse completes, new one after wrap ----
    cfg_duty[0] = 3; cfg_pin[0] = 5;
    for (int k = 1; k < 4; k++) begin cfg_duty[k] = 0; cfg_pin[k] = 63; end
    program_cfg(0, 9);
    for (int j = 0; j <= 20; j++) begin
      @(posedge clk); #2;
      rdr(8'h06, rd); chk("count_cycle", 64'(rd), 64'(j % 10));
      if (j >= 1)
        chk("duty_update_pwm5", 64'(pwm[5]), 64'(((j >= 1 && j <= 3) || (j >= 11 && j <= 17)) ? 1 : 0));
      if (j == 2) begin
        bus_if.sel = 1'b1; bus_if.addr = 8'h10; bus_if.dwrite = 16'd7; bus_if.w = 2'b11;
        @(negedge clk); #1;
        bus_if.sel = 1'b0; bus_if.w = 2'b00;
      end
    end

    // ---- WRAPF sticky, clear, and clear colliding with a wrap ----
    rdr(8'h00, rd); chk("wrapf_set", 64'(rd), 64'h8001);
    wr(8'h00, 16'h8000, 2'b10);
    rdr(8'h00, rd); chk("wrapf_cleared", 64'(rd), 64'h0001);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(posedge clk); #1;
      if (wrap) begin
        found = 1;
        bus_if.sel = 1'b1; bus_if.addr = 8'h00; bus_if.dwrite = 16'h8000; bus_if.w = 2'b10;
        @(negedge clk); #1;
        bus_if.sel = 1'b0; bus_if.w = 2'b00;
      end
    end
    chk("wrap_seen", 64'(found), 64'd1);
    rdr(8'h00, rd); chk("wrapf_set_wins", 64'(rd), 64'h8001);
    @(posedge clk); #2;
    rdr(8'h00, rd); chk("wrapf_sticky", 64'(rd), 64'h8001);

    // ---- asynchronous reset mid-period ----
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(posedge clk); #2;
      if (pwm[5]) found = 1;
    end
    chk("pwm_high_before_reset", 64'(found), 64'd1);
    nreset = 1'b0;
    #1;
    chk("midreset_pwm", 64'(pwm), 64'd0);
    chk("midreset_wrap", 64'(wrap), 64'd0);
    rdr(8'h06, rd); chk("midreset_count", 64'(rd), 64'd0);
    rdr(8'h10, rd); chk("midreset_duty0", 64'(rd), 64'd0);
    @(negedge clk); #2 nreset = 1'b1;
    repeat (3) @(posedge clk);
    #2 chk("post_reset_pwm", 64'(pwm), 64'd0);

    // ---- randomized configurations against the arithmetic model ----
    for (int t = 0; t < 8; t++) begin
      p   = int'($urandom_range(0, 3));
      per = int'($urandom_range(0, 12));
      for (int k = 0; k < 4; k++) begin
        cfg_duty[k] = int'($urandom_range(0, 15));
        cfg_pin[k]  = int'($urandom_range(0, 47));
      end
      program_cfg(p, per);
      $display("rand %0d: presc=%0d period=%0d duty=%0d,%0d,%0d,%0d pin=%0d,%0d,%0d,%0d",
               t, p, per, cfg_duty[0], cfg_duty[1], cfg_duty[2], cfg_duty[3],
               cfg_pin[0], cfg_pin[1], cfg_pin[2], cfg_pin[3]);
      for (int j = 0; j <= 40; j++) begin
        @(posedge clk); #2;
        if (j >= 1) begin
          exp_pwm = '0;
          for (int k = 0; k < 4; k++)
            if (cfg_pin[k] < 36 && mcnt(j - 1, p, per) < cfg_duty[k]) exp_pwm[cfg_pin[k]] = 1'b1;
          exp_wrap = ((j % (p + 1)) == 0) && (mcnt(j, p, per) == 0);
          chk("rand_pwm", 64'(pwm), 64'(exp_pwm));
          chk("rand_wrap", 64'(wrap), 64'(exp_wrap));
          rdr(8'h06, rd); chk("rand_count", 64'(rd), 64'(mcnt(j, p, per)));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
